// File: rtl/irq_timer_ctrl_if.sv
// Control-unit side signal bundle of the interrupt/timer controller.
// master = control unit (drives strobes), slave = irq_timer_ctrl.
interface irq_timer_ctrl_if;
    logic       cfg_we;
    logic [7:0] cfg_data;
    logic       ext_irq;
    logic       push;
    logic       pop;
    logic       interrupcion;
    logic       clock_out;
    logic       in_service;
    logic       ext_pending;
    logic       timer_pending;
    logic       depth_ovf;

    modport master (
        output cfg_we, cfg_data, ext_irq, push, pop,
        input  interrupcion, clock_out, in_service, ext_pending, timer_pending, depth_ovf
    );

    modport slave (
        input  cfg_we, cfg_data, ext_irq, push, pop,
        output interrupcion, clock_out, in_service, ext_pending, timer_pending, depth_ovf
    );
endinterface

// File: rtl/irq_timer_ctrl.sv
// Interrupt/timer controller: programmable periodic timer, external edge latch,
// ext-over-timer arbitration and ISR call-depth tracking via push/pop strobes.
module irq_timer_ctrl #(
    parameter int PRESC_W = 12,
    parameter int DEPTH_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    irq_timer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK_EXT = 2'd1,
        ACK_TMR = 2'd2,
        SERVICE = 2'd3
    } state_t;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

    state_t               state_r, state_nxt_s;
    logic [1:0]           base_r;
    logic [5:0]           thr_r;
    logic [PRESC_W-1:0]   presc_r;
    logic [PRESC_W-1:0]   div_m1_s;
    logic [5:0]           cnt_r;
    logic                 ext_irq_q_r;
    logic                 ext_pending_r;
    logic                 timer_pending_r;
    logic [DEPTH_W-1:0]   depth_r;
    logic                 depth_ovf_r;
    logic                 interrupcion_r, clock_out_r, in_service_r;
    logic                 irq_nxt_s, clk_out_nxt_s, in_service_nxt_s;
    logic                 tick_s, expire_s, ext_edge_s, take_ext_s, take_tmr_s;
    logic                 push_only_s, pop_only_s;

    // Prescaler terminal value: divisor 2^(4*base) minus one.
    always_comb begin
        div_m1_s = PRESC_W'(12'h000);
        case (base_r)
            2'd0:    div_m1_s = PRESC_W'(12'h000);
            2'd1:    div_m1_s = PRESC_W'(12'h00F);
            2'd2:    div_m1_s = PRESC_W'(12'h0FF);
            2'd3:    div_m1_s = PRESC_W'(12'hFFF);
            default: div_m1_s = PRESC_W'(12'h000);
        endcase
    end

    assign tick_s      = (presc_r == div_m1_s);
    assign expire_s    = tick_s && (thr_r != 6'd0) && (cnt_r == (thr_r - 6'd1));
    assign ext_edge_s  = bus.ext_irq & ~ext_irq_q_r;
    assign take_ext_s  = (state_r == IDLE) && ext_pending_r;
    assign take_tmr_s  = (state_r == IDLE) && !ext_pending_r && timer_pending_r;
    assign push_only_s = bus.push & ~bus.pop;
    assign pop_only_s  = bus.pop & ~bus.push;

    // Timer configuration, prescaler and tick counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_r  <= 2'd0;
            thr_r   <= 6'd0;
            presc_r <= PRESC_W'(12'h000);
            cnt_r   <= 6'd0;
        end else if (bus.cfg_we) begin
            base_r  <= bus.cfg_data[7:6];
            thr_r   <= bus.cfg_data[5:0];
            presc_r <= PRESC_W'(12'h000);
            cnt_r   <= 6'd0;
        end else begin
            presc_r <= tick_s ? PRESC_W'(12'h000) : presc_r + PRESC_W'(12'h001);
            if (tick_s && (thr_r != 6'd0)) begin
                cnt_r <= expire_s ? 6'd0 : cnt_r + 6'd1;
            end
        end
    end

    // Pending request latches; a new event beats the clear on the same edge,
    // but a config write suppresses a coincident timer expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_irq_q_r     <= 1'b0;
            ext_pending_r   <= 1'b0;
            timer_pending_r <= 1'b0;
        end else begin
            ext_irq_q_r <= bus.ext_irq;
            if (ext_edge_s) begin
                ext_pending_r <= 1'b1;
            end else if (take_ext_s) begin
                ext_pending_r <= 1'b0;
            end
            if (bus.cfg_we) begin
                timer_pending_r <= 1'b0;
            end else if (expire_s) begin
                timer_pending_r <= 1'b1;
            end else if (take_tmr_s) begin
                timer_pending_r <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; leaving SERVICE only on the pop that empties the stack.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (take_ext_s) begin
                    state_nxt_s = ACK_EXT;
                end else if (take_tmr_s) begin
                    state_nxt_s = ACK_TMR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACK_EXT, ACK_TMR: state_nxt_s = SERVICE;
            SERVICE: begin
                if (pop_only_s && (depth_r == DEPTH_W'(1'b1))) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SERVICE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode, taken from the next state so the outputs can be registered.
    always_comb begin
        irq_nxt_s        = (state_nxt_s == ACK_EXT);
        clk_out_nxt_s    = (state_nxt_s == ACK_TMR);
        in_service_nxt_s = (state_nxt_s != IDLE);
    end

    // Registered request/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            interrupcion_r <= 1'b0;
            clock_out_r    <= 1'b0;
            in_service_r   <= 1'b0;
        end else begin
            interrupcion_r <= irq_nxt_s;
            clock_out_r    <= clk_out_nxt_s;
            in_service_r   <= in_service_nxt_s;
        end
    end

    // ISR call depth; the ACK cycle preloads 1 for the unit's entry push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth_r     <= '0;
            depth_ovf_r <= 1'b0;
        end else if ((state_r == ACK_EXT) || (state_r == ACK_TMR)) begin
            depth_r <= DEPTH_W'(1'b1);
        end else if (state_r == SERVICE) begin
            if (push_only_s) begin
                if (depth_r == DEPTH_MAX) begin
                    depth_ovf_r <= 1'b1;
                end else begin
                    depth_r <= depth_r + DEPTH_W'(1'b1);
                end
            end else if (pop_only_s && (depth_r != '0)) begin
                depth_r <= depth_r - DEPTH_W'(1'b1);
            end
        end
    end

    assign bus.interrupcion  = interrupcion_r;
    assign bus.clock_out     = clock_out_r;
    assign bus.in_service    = in_service_r;
    assign bus.ext_pending   = ext_pending_r;
    assign bus.timer_pending = timer_pending_r;
    assign bus.depth_ovf     = depth_ovf_r;
endmodule

// File: doc/irq_timer_ctrl.md
Name: irq_timer_ctrl

Overview:
Interrupt and timer controller that drives the control unit's `interrupcion` and `clock_out` request inputs.
- Holds a programmable periodic timer, configured by the `clk_conf` instruction through the unit's `enable` strobe.
- Latches external interrupt edges and arbitrates them against timer expiry.
- Tracks the service routine's call depth via the unit's `push`/`pop` strobes, so a new request is issued only after the ISR has returned.

Parameters:
PRESC_W, 12, prescaler width; must be ≥ 12 to support base 3 (divide by 4096).
DEPTH_W, 4, width of the ISR call-depth counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
cfg_we  input  1  config strobe (control unit `enable`).
cfg_data  input  8  [7:6] base select, [5:0] threshold.
ext_irq  input  1  external interrupt level, synchronous to clk.
push  input  1  control unit stack push strobe.
pop  input  1  control unit stack pop strobe.
interrupcion  output  1  external-interrupt request pulse to the control unit.
clock_out  output  1  timer-interrupt request pulse to the control unit.
in_service  output  1  high while a request is acknowledged or being serviced.
ext_pending  output  1  latched external request not yet issued.
timer_pending  output  1  latched timer expiry not yet issued.
depth_ovf  output  1  sticky flag: push seen at maximum depth.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; state IDLE.
  - base=0, thr=0, prescaler=0, tick count=0, depth=0, ext_irq_q=0.
- Config write (cfg_we=1 at a clock edge):
  - base<=cfg_data[7:6]; thr<=cfg_data[5:0].
  - Prescaler, tick count and timer_pending cleared.
  - A config write in the same edge as a timer expiry wins: no pending is set.
  - thr=0 disables the timer.
  - State, depth and ext_pending are unaffected.
- Prescaler:
  - Divisor is 2^(4*base): 1, 16, 256 or 4096.
  - Emits a one-cycle tick when it reaches divisor-1, then wraps to 0.
  - With base=0, a tick occurs every cycle.
- Tick counter (6-bit), only when thr≠0:
  - On a tick, if count==thr-1: count<=0 and timer_pending<=1. Otherwise count+1.
  - Timer period is thr*2^(4*base) cycles.
  - An expiry while already pending is lost; the flag stays 1.
- External edge:
  - ext_irq_q registers ext_irq.
  - ext_irq & ~ext_irq_q sets ext_pending at that edge.
  - If the set coincides with a clear, set wins.
- FSM states IDLE, ACK, SERVICE:
  - IDLE: if ext_pending, go to ACK_EXT and clear ext_pending. Else if timer_pending, go to ACK_TMR and clear timer_pending. Else stay.
  - External has priority over timer.
  - ACK: interrupcion (ACK_EXT) or clock_out (ACK_TMR) is 1 for exactly this one cycle. These are registered and never both high. Next edge goes to SERVICE with depth<=1, accounting for the unit's entry push.
  - SERVICE:
    - push&~pop: depth+1, saturating at 2^DEPTH_W-1; a push at saturation sets depth_ovf.
    - pop&~push: depth-1; if depth==1, depth<=0 and go to IDLE.
    - push&pop: no change.
    - pop at depth 0 is ignored.
  - in_service = (state≠IDLE).
  - Requests arriving during ACK/SERVICE are latched and issued from IDLE, one cycle after return at the earliest.
- Latency:
  - ext_irq rises before edge N → ext_pending=1 after N, interrupcion=1 during cycle N+1→N+2, in_service=1 from N+1.
  - Timer expiry follows the same path: timer_pending high → clock_out one cycle later.
- Outside SERVICE, push/pop have no effect on depth.
- Reset mid-service: returns to IDLE at once and all pending requests are lost.

Test Plan:
- Reset, then cfg_we with cfg_data=8'h43 (base 1, thr 3) → timer_pending rises at the 48th edge after the write edge, clock_out pulses 1 cycle later, in_service=1.
- ext_irq 0→1 in IDLE → ext_pending=1, then interrupcion 1-cycle pulse; in SERVICE, push,push,pop,pop,pop → in_service drops only after the third pop (depth 1→3→0).
- ext and timer pending simultaneously in IDLE → interrupcion issued first; after return, clock_out issued on the second cycle after leaving SERVICE.
- cfg_data=8'h00 write → no clock_out for 10000 cycles; cfg write on an expiry edge → timer_pending stays 0.
- DEPTH_W=4: 15 pushes in SERVICE → depth saturates at 15, depth_ovf=1 and stays 1 until reset.
- reset asserted mid-SERVICE with ext_pending=1 → all outputs 0 immediately, no request after reset release.
